// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use, taken branch,
// iterative divide and data-bus wait states, plus a free-running stall counter.
module pipe_hazard_ctrl #(
    parameter int unsigned DIV_CYCLES = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1_raddr_i,
    input  logic [4:0]  id_rs2_raddr_i,
    input  logic        id_rs1_used_i,
    input  logic        id_rs2_used_i,
    input  logic [4:0]  ex_reg_waddr_i,
    input  logic        ex_is_load_i,
    input  logic        ex_branch_taken_i,
    input  logic        ex_div_start_i,
    input  logic        mem_req_i,
    input  logic        mem_ack_i,
    output logic        pc_stall_o,
    output logic        if_id_stall_o,
    output logic        id_ex_stall_o,
    output logic        ex_mem_stall_o,
    output logic        if_id_flush_o,
    output logic        id_ex_flush_o,
    output logic        ex_mem_flush_o,
    output logic        mem_wb_flush_o,
    output logic        busy_o,
    output logic [1:0]  state_o,
    output logic [31:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DIV_WAIT = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    // The entry cycle in RUN is the first EX cycle, so DIV_WAIT counts the rest.
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 2);

    state_e      state_q, state_d;
    logic [5:0]  div_cnt_q, div_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        load_use;

    assign load_use = ex_is_load_i && (ex_reg_waddr_i != 5'd0) &&
                      ((id_rs1_used_i && (id_rs1_raddr_i == ex_reg_waddr_i)) ||
                       (id_rs2_used_i && (id_rs2_raddr_i == ex_reg_waddr_i)));

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d        = state_q;
        div_cnt_d      = div_cnt_q;
        pc_stall_o     = 1'b0;
        if_id_stall_o  = 1'b0;
        id_ex_stall_o  = 1'b0;
        ex_mem_stall_o = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_flush_o = 1'b0;
        mem_wb_flush_o = 1'b0;

        unique case (state_q)
            RUN: begin
                if (mem_req_i && !mem_ack_i) begin
                    pc_stall_o     = 1'b1;
                    if_id_stall_o  = 1'b1;
                    id_ex_stall_o  = 1'b1;
                    ex_mem_stall_o = 1'b1;
                    mem_wb_flush_o = 1'b1;
                    state_d        = MEM_WAIT;
                end else if (ex_div_start_i) begin
                    pc_stall_o     = 1'b1;
                    if_id_stall_o  = 1'b1;
                    id_ex_stall_o  = 1'b1;
                    ex_mem_flush_o = 1'b1;
                    div_cnt_d      = DIV_LOAD;
                    state_d        = DIV_WAIT;
                end else if (ex_branch_taken_i) begin
                    if_id_flush_o = 1'b1;
                    id_ex_flush_o = 1'b1;
                end else if (load_use) begin
                    pc_stall_o    = 1'b1;
                    if_id_stall_o = 1'b1;
                    id_ex_flush_o = 1'b1;
                end
            end
            DIV_WAIT: begin
                // MEM holds a bubble while dividing, so bus and ID inputs are moot.
                if (div_cnt_q != 6'd0) begin
                    pc_stall_o     = 1'b1;
                    if_id_stall_o  = 1'b1;
                    id_ex_stall_o  = 1'b1;
                    ex_mem_flush_o = 1'b1;
                    div_cnt_d      = div_cnt_q - 6'd1;
                end else begin
                    state_d = RUN;
                end
            end
            MEM_WAIT: begin
                if (!mem_ack_i) begin
                    pc_stall_o     = 1'b1;
                    if_id_stall_o  = 1'b1;
                    id_ex_stall_o  = 1'b1;
                    ex_mem_stall_o = 1'b1;
                    mem_wb_flush_o = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign stall_cnt_d = stall_cnt_q + 32'(pc_stall_o);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            div_cnt_q   <= 6'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign busy_o      = (state_q != RUN);
    assign state_o     = state_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hand-computed stall/flush vectors, state,
// busy and stall counter, plus a DIV_CYCLES=2 instance for the short-divide edge.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs1_raddr, id_rs2_raddr, ex_reg_waddr;
    logic        id_rs1_used, id_rs2_used, ex_is_load, ex_branch_taken;
    logic        ex_div_start, mem_req, mem_ack;

    logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic        busy;
    logic [1:0]  state;
    logic [31:0] stall_cnt;

    logic        pc_stall2, if_id_stall2, id_ex_stall2, ex_mem_stall2;
    logic        if_id_flush2, id_ex_flush2, ex_mem_flush2, mem_wb_flush2;
    logic        busy2;
    logic [1:0]  state2;
    logic [31:0] stall_cnt2;

    int checks = 0;
    int failures = 0;

    // Output vector order: {pc,if_id,id_ex,ex_mem stalls, if_id,id_ex,ex_mem,mem_wb flushes}
    localparam logic [7:0] O_NONE = 8'b0000_0000;
    localparam logic [7:0] O_LU   = 8'b1100_0100;
    localparam logic [7:0] O_BR   = 8'b0000_1100;
    localparam logic [7:0] O_DIV  = 8'b1110_0010;
    localparam logic [7:0] O_MEM  = 8'b1111_0001;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.DIV_CYCLES(33)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_raddr_i(id_rs1_raddr), .id_rs2_raddr_i(id_rs2_raddr),
        .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
        .ex_reg_waddr_i(ex_reg_waddr), .ex_is_load_i(ex_is_load),
        .ex_branch_taken_i(ex_branch_taken), .ex_div_start_i(ex_div_start),
        .mem_req_i(mem_req), .mem_ack_i(mem_ack),
        .pc_stall_o(pc_stall), .if_id_stall_o(if_id_stall),
        .id_ex_stall_o(id_ex_stall), .ex_mem_stall_o(ex_mem_stall),
        .if_id_flush_o(if_id_flush), .id_ex_flush_o(id_ex_flush),
        .ex_mem_flush_o(ex_mem_flush), .mem_wb_flush_o(mem_wb_flush),
        .busy_o(busy), .state_o(state), .stall_cnt_o(stall_cnt)
    );

    pipe_hazard_ctrl #(.DIV_CYCLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_raddr_i(id_rs1_raddr), .id_rs2_raddr_i(id_rs2_raddr),
        .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
        .ex_reg_waddr_i(ex_reg_waddr), .ex_is_load_i(ex_is_load),
        .ex_branch_taken_i(ex_branch_taken), .ex_div_start_i(ex_div_start),
        .mem_req_i(mem_req), .mem_ack_i(mem_ack),
        .pc_stall_o(pc_stall2), .if_id_stall_o(if_id_stall2),
        .id_ex_stall_o(id_ex_stall2), .ex_mem_stall_o(ex_mem_stall2),
        .if_id_flush_o(if_id_flush2), .id_ex_flush_o(id_ex_flush2),
        .ex_mem_flush_o(ex_mem_flush2), .mem_wb_flush_o(mem_wb_flush2),
        .busy_o(busy2), .state_o(state2), .stall_cnt_o(stall_cnt2)
    );

    function automatic logic [7:0] outs();
        return {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
    endfunction

    function automatic logic [7:0] outs2();
        return {pc_stall2, if_id_stall2, id_ex_stall2, ex_mem_stall2,
                if_id_flush2, id_ex_flush2, ex_mem_flush2, mem_wb_flush2};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic idle();
        id_rs1_raddr = 5'd0; id_rs2_raddr = 5'd0;
        id_rs1_used = 1'b0;  id_rs2_used = 1'b0;
        ex_reg_waddr = 5'd0; ex_is_load = 1'b0;
        ex_branch_taken = 1'b0; ex_div_start = 1'b0;
        mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    // Advance one clock; inputs change on the falling edge, outputs settle by +1.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        do_reset();

        // Reset state
        check("rst_outs", 32'(outs()), 32'(O_NONE));
        check("rst_state", 32'(state), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt", stall_cnt, 32'd0);

        // Load-use: lw x5 in EX, add reading x5 via rs2
        ex_is_load = 1'b1; ex_reg_waddr = 5'd5;
        id_rs2_used = 1'b1; id_rs2_raddr = 5'd5; id_rs1_used = 1'b1; id_rs1_raddr = 5'd3;
        #1 check("lu_rs2", 32'(outs()), 32'(O_LU));
        step();
        idle();
        #1 check("lu_cnt", stall_cnt, 32'd1);
        check("lu_state", 32'(state), 32'd0);
        check("lu_one_bubble", 32'(outs()), 32'(O_NONE));

        // rs1 matches but is not read -> no hazard
        ex_is_load = 1'b1; ex_reg_waddr = 5'd7; id_rs1_raddr = 5'd7; id_rs1_used = 1'b0;
        #1 check("lu_rs1_unused", 32'(outs()), 32'(O_NONE));
        id_rs1_used = 1'b1;
        #1 check("lu_rs1", 32'(outs()), 32'(O_LU));
        idle();

        // Load to x0 never stalls
        ex_is_load = 1'b1; ex_reg_waddr = 5'd0; id_rs2_used = 1'b1; id_rs2_raddr = 5'd0;
        #1 check("lu_x0", 32'(outs()), 32'(O_NONE));

        // Branch overrides load-use
        ex_reg_waddr = 5'd5; id_rs2_raddr = 5'd5; ex_branch_taken = 1'b1;
        #1 check("br_lu", 32'(outs()), 32'(O_BR));
        step();
        idle();
        #1 check("br_cnt", stall_cnt, 32'd1);

        // Div, 33 cycles: entry stall plus 32 DIV_WAIT cycles (31 stalled, 1 release)
        ex_div_start = 1'b1; ex_branch_taken = 1'b1;
        #1 check("div_entry", 32'(outs()), 32'(O_DIV));
        check("div_entry_state", 32'(state), 32'd0);
        step();
        idle();
        for (int i = 0; i < 32; i++) begin
            check($sformatf("div_state_%0d", i), 32'(state), 32'd1);
            check($sformatf("div_busy_%0d", i), 32'(busy), 32'd1);
            check($sformatf("div_outs_%0d", i), 32'(outs()),
                  (i < 31) ? 32'(O_DIV) : 32'(O_NONE));
            step();
        end
        check("div_done_state", 32'(state), 32'd0);
        check("div_done_busy", 32'(busy), 32'd0);
        check("div_cnt", stall_cnt, 32'd33);

        // Mem wait: ack three cycles after the request
        mem_req = 1'b1;
        #1 check("mem_run", 32'(outs()), 32'(O_MEM));
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("mem_wait_state_%0d", i), 32'(state), 32'd2);
            check($sformatf("mem_wait_outs_%0d", i), 32'(outs()), 32'(O_MEM));
        end
        step();
        mem_ack = 1'b1;
        #1 check("mem_ack_outs", 32'(outs()), 32'(O_NONE));
        check("mem_ack_state", 32'(state), 32'd2);
        step();
        check("mem_done_state", 32'(state), 32'd0);
        check("mem_cnt", stall_cnt, 32'd36);

        // Same-cycle ack costs nothing
        mem_req = 1'b1; mem_ack = 1'b1;
        #1 check("mem_fast_outs", 32'(outs()), 32'(O_NONE));
        step();
        check("mem_fast_state", 32'(state), 32'd0);
        check("mem_fast_cnt", stall_cnt, 32'd36);

        // Div held behind a memory stall starts after the ack
        mem_req = 1'b1; mem_ack = 1'b0; ex_div_start = 1'b1;
        #1 check("memdiv_run", 32'(outs()), 32'(O_MEM));
        step();
        step();
        check("memdiv_wait", 32'(outs()), 32'(O_MEM));
        mem_ack = 1'b1;
        #1 check("memdiv_ack", 32'(outs()), 32'(O_NONE));
        step();
        mem_req = 1'b0; mem_ack = 1'b0;
        #1 check("memdiv_start", 32'(outs()), 32'(O_DIV));
        check("memdiv_start_state", 32'(state), 32'd0);
        step();
        ex_div_start = 1'b0;
        check("memdiv_in_div", 32'(state), 32'd1);

        // Run down to div_cnt=10 (entered at 31), then reset asynchronously
        for (int i = 0; i < 21; i++) step();
        check("pre_rst_outs", 32'(outs()), 32'(O_DIV));
        #2 rst_n = 1'b0;
        #1 check("arst_state", 32'(state), 32'd0);
        check("arst_outs", 32'(outs()), 32'(O_NONE));
        check("arst_cnt", stall_cnt, 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_outs", 32'(outs()), 32'(O_NONE));
        check("post_rst_state", 32'(state), 32'd0);

        // Counter wrap from 2^32-2 through a memory stall
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1 release dut.stall_cnt_q;
        mem_req = 1'b1;
        step();
        check("wrap_max", stall_cnt, 32'hFFFF_FFFF);
        step();
        check("wrap_zero", stall_cnt, 32'd0);
        step();
        check("wrap_one", stall_cnt, 32'd1);
        mem_ack = 1'b1;
        step();
        idle();

        // DIV_CYCLES=2, back-to-back divs with start held high
        do_reset();
        ex_div_start = 1'b1;
        #1 check("d2_entry", 32'(outs2()), 32'(O_DIV));
        step();
        check("d2_wait_state", 32'(state2), 32'd1);
        check("d2_wait_outs", 32'(outs2()), 32'(O_NONE));
        step();
        check("d2_b2b_state", 32'(state2), 32'd0);
        check("d2_b2b_outs", 32'(outs2()), 32'(O_DIV));
        step();
        check("d2_b2b_wait", 32'(state2), 32'd1);
        ex_div_start = 1'b0;
        step();
        check("d2_done_state", 32'(state2), 32'd0);
        check("d2_cnt", stall_cnt2, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the five-stage integer pipeline. Watches the ID, EX and MEM stages and drives hold (stall) and bubble (flush) controls into the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Covers three hazards:
- load-use data hazards
- taken branches/jumps resolved in EX
- multi-cycle operations: the iterative divider in EX and data-bus wait states in MEM

Keeps a free-running stall-cycle counter for performance monitoring.

## Interface
- DIV_CYCLES, 33, cycles a div/rem instruction occupies EX, entry cycle included; legal range 2..64
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- id_rs1_raddr_i  in  5  rs1 index of instruction in ID
- id_rs2_raddr_i  in  5  rs2 index of instruction in ID
- id_rs1_used_i  in  1  ID instruction reads rs1
- id_rs2_used_i  in  1  ID instruction reads rs2
- ex_reg_waddr_i  in  5  destination index of instruction in EX
- ex_is_load_i  in  1  EX instruction is a load
- ex_branch_taken_i  in  1  EX instruction redirects PC this cycle
- ex_div_start_i  in  1  EX instruction is div/divu/rem/remu
- mem_req_i  in  1  MEM stage drives a data-bus request
- mem_ack_i  in  1  data bus completes the request this cycle
- pc_stall_o  out  1  hold PC
- if_id_stall_o  out  1  hold IF/ID
- id_ex_stall_o  out  1  hold ID/EX
- ex_mem_stall_o  out  1  hold EX/MEM
- if_id_flush_o  out  1  load NOP into IF/ID
- id_ex_flush_o  out  1  load NOP into ID/EX
- ex_mem_flush_o  out  1  load NOP into EX/MEM
- mem_wb_flush_o  out  1  load NOP into MEM/WB
- busy_o  out  1  FSM not in RUN
- state_o  out  2  RUN=0, DIV_WAIT=1, MEM_WAIT=2
- stall_cnt_o  out  32  cycles with pc_stall_o=1 since reset, wraps modulo 2^32

## Operation

**Signal rules**
- Stall and flush outputs are combinational from current state, counter and inputs.
- Stall of a register has priority over flush of the same register inside the register. This block never asserts both for one register.

**FSM states:** RUN, DIV_WAIT, MEM_WAIT; 6-bit down-counter div_cnt.

**RUN priority, highest first**
1. Memory stall: mem_req_i=1 and mem_ack_i=0.
   - Assert all four stalls and mem_wb_flush_o.
   - Next state MEM_WAIT.
   - Branch, div and load-use handling suppressed this cycle.
2. Div start: ex_div_start_i=1.
   - Assert pc/if_id/id_ex stalls and ex_mem_flush_o.
   - div_cnt<=DIV_CYCLES-2; next state DIV_WAIT.
   - ex_branch_taken_i ignored.
3. Branch: ex_branch_taken_i=1.
   - Assert if_id_flush_o and id_ex_flush_o, no stalls.
   - Load-use ignored, because the ID instruction is discarded.
4. Load-use: ex_is_load_i=1 and ex_reg_waddr_i!=0, plus either (id_rs1_used_i and id_rs1_raddr_i==ex_reg_waddr_i) or (id_rs2_used_i and id_rs2_raddr_i==ex_reg_waddr_i).
   - Assert pc_stall_o, if_id_stall_o and id_ex_flush_o.
   - Exactly one bubble; stay RUN.
5. Otherwise all stall/flush outputs 0.

**DIV_WAIT**
- div_cnt!=0: pc/if_id/id_ex stalls plus ex_mem_flush_o; div_cnt decrements.
- div_cnt==0: all outputs 0, so the result latches into EX/MEM; next RUN.
- mem_req_i, mem_ack_i, branch and load-use inputs are ignored, since MEM holds a bubble.

**MEM_WAIT**
- mem_ack_i=0: all four stalls plus mem_wb_flush_o; stay.
- mem_ack_i=1: all outputs 0; next RUN.

**stall_cnt_o** increments on every clock edge where pc_stall_o=1.

## Timing
- Reset values: state RUN, div_cnt 0, stall_cnt_o 0, busy_o 0, state_o 0. With all inputs 0, every stall/flush output is 0.
- Reset asserted mid-DIV_WAIT or mid-MEM_WAIT returns to RUN asynchronously. No stall persists after release.
- Load-use penalty: exactly 1 cycle.
- Branch penalty: 2 flushed slots, 0 stall cycles.
- Div: EX is occupied DIV_CYCLES cycles, with DIV_CYCLES-1 stall cycles (entry cycle included). DIV_CYCLES=2 gives one stall cycle and one DIV_WAIT cycle with div_cnt=0.
- Mem: a same-cycle ack gives 0 stall cycles. An ack N cycles after the request gives N stall cycles.
- Back-to-back divs: the second div is seen in RUN the cycle after release and re-enters DIV_WAIT.
- Div held behind a MEM stall: it starts on the first RUN cycle after the ack.

## Test plan
- Load-use: lw x5 in EX, add reading x5 (rs2) in ID.
  - pc_stall_o=if_id_stall_o=id_ex_flush_o=1 for 1 cycle; stall_cnt_o +1.
  - Same with ex_reg_waddr_i=0 → no stall.
- Branch + hazard: ex_branch_taken_i=1 together with a load-use match → if_id_flush_o=id_ex_flush_o=1, pc_stall_o=0.
- Div, DIV_CYCLES=33: ex_div_start_i held → stalls and ex_mem_flush_o for 32 cycles, release on the 33rd, busy_o=1 for 32 cycles, stall_cnt_o=32.
- Mem wait: mem_req_i=1, ack after 3 cycles → 3 stall cycles with mem_wb_flush_o=1, state_o=2. Then add a concurrent ex_div_start_i → div begins after the ack.
- Reset mid-DIV_WAIT at div_cnt=10 → state_o=0, all outputs 0, stall_cnt_o=0 immediately.
- stall_cnt_o preloaded near 2^32-1 via long mem waits (or forced) → wraps to 0 cleanly.
